// File: rtl/mem_responder.sv
// Wait-state memory responder for the CPU data port: accepts one RD_EN/WR_EN
// request, counts WAIT_STATES cycles, then completes with a one-cycle ready pulse.
module mem_responder #(
  parameter int DATA_WIDTH  = 19,
  parameter int ADDR_WIDTH  = 19,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  output logic [15:0]           txn_count
);

  localparam int                IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]        LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_wr;
  logic                  r_bad;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [15:0]           r_txn;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_bad_in;
  logic                  w_from_in;
  logic [IDX_W-1:0]      w_op_idx;
  logic [DATA_WIDTH-1:0] w_op_wdata;
  logic                  w_op_is_wr;
  logic                  w_op_bad;
  logic                  w_enter_resp;
  logic                  w_mem_we;

  assign w_accept = (r_state == S_IDLE) && (rd_en || wr_en);
  assign w_bad_in = (rd_en && wr_en) || ({1'b0, addr} >= LP_DEPTH);

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // memory operation must take the live inputs instead of the latched copies.
  assign w_from_in  = (r_state == S_IDLE);
  assign w_op_idx   = w_from_in ? addr[IDX_W-1:0] : r_idx;
  assign w_op_wdata = w_from_in ? wdata : r_wdata;
  assign w_op_is_wr = w_from_in ? (wr_en && !rd_en) : r_is_wr;
  assign w_op_bad   = w_from_in ? w_bad_in : r_bad;

  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
  assign w_mem_we     = w_enter_resp && w_op_is_wr && !w_op_bad && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == S_RESP);
    err   = (r_state == S_RESP) && r_err;
    busy  = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_bad   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= LP_WAIT_LOAD;
      r_idx   <= addr[IDX_W-1:0];
      r_wdata <= wdata;
      r_is_wr <= wr_en && !rd_en;
      r_bad   <= w_bad_in;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  // rdata holds between completions; writes leave it untouched, errors zero it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_txn   <= 16'd0;
    end else if (w_enter_resp) begin
      r_err <= w_op_bad;
      if (w_op_bad) begin
        r_rdata <= '0;
      end else begin
        r_txn <= r_txn + 16'd1;
        if (!w_op_is_wr) begin
          r_rdata <= r_mem[w_op_idx];
        end
      end
    end
  end

  assign rdata     = r_rdata;
  assign txn_count = r_txn;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with
// zero wait states, sharing clock and reset.
module tb_mem_responder;

  logic        clk;
  logic        reset;

  logic        a_rd, a_wr;
  logic [18:0] a_addr, a_wdata, a_rdata;
  logic        a_ready, a_err, a_busy;
  logic [15:0] a_txn;

  logic        z_rd, z_wr;
  logic [18:0] z_addr, z_wdata, z_rdata;
  logic        z_ready, z_err, z_busy;
  logic [15:0] z_txn;

  int n_vec;
  int n_miss;

  mem_responder #(.DATA_WIDTH(19), .ADDR_WIDTH(19), .DEPTH(1024), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset), .rd_en(a_rd), .wr_en(a_wr), .addr(a_addr), .wdata(a_wdata),
    .rdata(a_rdata), .ready(a_ready), .err(a_err), .busy(a_busy), .txn_count(a_txn)
  );

  mem_responder #(.DATA_WIDTH(19), .ADDR_WIDTH(19), .DEPTH(1024), .WAIT_STATES(0)) u_dut_z (
    .clk(clk), .reset(reset), .rd_en(z_rd), .wr_en(z_wr), .addr(z_addr), .wdata(z_wdata),
    .rdata(z_rdata), .ready(z_ready), .err(z_err), .busy(z_busy), .txn_count(z_txn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds the request until ready; returns with the bench inside the ready cycle.
  task automatic req_a(input logic rd, input logic wr, input logic [18:0] ad,
                       input logic [18:0] wd, output int lat);
    a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (a_ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic req_z(input logic rd, input logic wr, input logic [18:0] ad,
                       input logic [18:0] wd, output int lat);
    z_rd = rd; z_wr = wr; z_addr = ad; z_wdata = wd;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (z_ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    z_rd = 1'b0; z_wr = 1'b0;
  endtask

  initial begin
    int lat;
    int n_rdy;
    int last_rdy;
    int gap_bad;
    n_vec = 0; n_miss = 0;
    reset = 1'b0;
    a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    z_rd = 0; z_wr = 0; z_addr = '0; z_wdata = '0;
    repeat (3) step();
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_ready", {31'd0, a_ready}, 32'd0);
      chk("idle_err",   {31'd0, a_err},   32'd0);
      chk("idle_busy",  {31'd0, a_busy},  32'd0);
      chk("idle_rdata", {13'd0, a_rdata}, 32'd0);
      chk("idle_txn",   {16'd0, a_txn},   32'd0);
    end
    chk("idle_z_busy", {31'd0, z_busy}, 32'd0);
    chk("idle_z_txn",  {16'd0, z_txn},  32'd0);

    // Write then read addr 5 with two wait states.
    req_a(1'b0, 1'b1, 19'd5, 19'h1ABCD, lat);
    chk("wr5_lat", lat, 32'd3);
    chk("wr5_err", {31'd0, a_err}, 32'd0);
    chk("wr5_busy", {31'd0, a_busy}, 32'd1);
    step();
    chk("wr5_busy_fall", {31'd0, a_busy}, 32'd0);
    chk("wr5_ready_fall", {31'd0, a_ready}, 32'd0);
    req_a(1'b1, 1'b0, 19'd5, 19'h0, lat);
    chk("rd5_lat", lat, 32'd3);
    chk("rd5_rdata", {13'd0, a_rdata}, 32'h1ABCD);
    chk("rd5_err", {31'd0, a_err}, 32'd0);
    chk("rd5_txn", {16'd0, a_txn}, 32'd2);
    step();
    chk("rd5_rdata_hold", {13'd0, a_rdata}, 32'h1ABCD);

    // Both strobes high at addr 7 must not disturb the stored word.
    req_a(1'b0, 1'b1, 19'd7, 19'h00777, lat);
    step();
    req_a(1'b1, 1'b1, 19'd7, 19'h12345, lat);
    chk("both_lat", lat, 32'd3);
    chk("both_err", {31'd0, a_err}, 32'd1);
    chk("both_rdata", {13'd0, a_rdata}, 32'd0);
    chk("both_txn", {16'd0, a_txn}, 32'd3);
    step();
    chk("both_err_fall", {31'd0, a_err}, 32'd0);
    req_a(1'b1, 1'b0, 19'd7, 19'h0, lat);
    chk("rd7_rdata", {13'd0, a_rdata}, 32'h00777);
    chk("rd7_err", {31'd0, a_err}, 32'd0);
    chk("rd7_txn", {16'd0, a_txn}, 32'd4);
    step();

    // First out-of-range address.
    req_a(1'b1, 1'b0, 19'd1024, 19'h0, lat);
    chk("oor_lat", lat, 32'd3);
    chk("oor_err", {31'd0, a_err}, 32'd1);
    chk("oor_rdata", {13'd0, a_rdata}, 32'd0);
    chk("oor_txn", {16'd0, a_txn}, 32'd4);
    step();

    // Zero wait states: strobe held, next request presented in each ready cycle.
    z_wr = 1'b1; z_addr = 19'd0; z_wdata = 19'h00100;
    n_rdy = 0; last_rdy = -1; gap_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (z_ready === 1'b1) begin
        if (last_rdy >= 0 && (i - last_rdy) != 2) gap_bad++;
        last_rdy = i;
        n_rdy++;
        if (n_rdy == 4) begin
          z_wr = 1'b0;
          break;
        end
        z_addr = 19'(n_rdy);
        z_wdata = 19'h00100 + 19'(n_rdy);
      end
    end
    chk("z_burst_count", n_rdy, 32'd4);
    chk("z_burst_last", last_rdy, 32'd7);
    chk("z_burst_gap", gap_bad, 32'd0);
    chk("z_burst_txn", {16'd0, z_txn}, 32'd4);
    step();
    for (int k = 0; k < 4; k++) begin
      req_z(1'b1, 1'b0, 19'(k), 19'h0, lat);
      chk("z_rb_lat", lat, 32'd1);
      chk("z_rb_rdata", {13'd0, z_rdata}, 32'h00100 + k);
      step();
    end
    chk("z_rb_txn", {16'd0, z_txn}, 32'd8);

    // Reset during WAIT discards the pending write to addr 9.
    req_a(1'b0, 1'b1, 19'd9, 19'h11111, lat);
    chk("wr9_txn", {16'd0, a_txn}, 32'd5);
    step();
    a_wr = 1'b1; a_addr = 19'd9; a_wdata = 19'h00042;
    step();
    chk("abort_busy_acc", {31'd0, a_busy}, 32'd1);
    step();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, a_busy}, 32'd0);
    chk("abort_txn", {16'd0, a_txn}, 32'd0);
    a_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_noready", {31'd0, a_ready}, 32'd0);
    end
    reset = 1'b1;
    step();
    chk("abort_noready_rel", {31'd0, a_ready}, 32'd0);
    req_a(1'b1, 1'b0, 19'd9, 19'h0, lat);
    chk("rd9_lat", lat, 32'd3);
    chk("rd9_rdata", {13'd0, a_rdata}, 32'h11111);
    chk("rd9_txn", {16'd0, a_txn}, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
